fetch_unit: RTL and testbench

- Front end of the single-cycle core. Owns the PC register and fetches each instruction from instruction memory over a valid/ready request and response handshake.
- Holds the fetched instruction stable until the core retires it, then updates the PC from the controller's pc_src selection.
- Directly upstream of the decoder/controller (supplies op/funct3/funct7b5 via instr). Consumes the controller's pc_src.

---
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Front end of the single-cycle core. Owns the PC and fetches one instruction
// at a time from instruction memory over a valid/ready request channel and a
// valid-only response channel. The fetched word is held stable until the core
// retires it. The PC then advances according to the controller's pc_src.
// A misaligned next-PC parks the unit in a terminal fault state until reset.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        retire,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_WAIT  = 2'b01,
        S_EXEC  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    // A fetch target must be word aligned; the core has no compressed ISA.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // jalr clears bit 0 of the computed target before use.
    function automatic logic [31:0] jalr_target(input logic [31:0] alu);
        return (alu & 32'hFFFF_FFFE);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        instr_valid_r;
    logic        fault_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] pc_branch_s;
    logic [31:0] next_pc_s;
    logic        pc_load_s;
    logic        capture_s;
    logic        fault_set_s;

    // Link address and branch target; both wrap silently modulo 2^32.
    assign pc_plus4_s  = pc_r + 32'h0000_0004;
    assign pc_branch_s = pc_r + imm_ext;

    // Next-PC selection; the reserved encoding falls back to sequential flow.
    always_comb begin
        next_pc_s = pc_plus4_s;
        case (pc_src)
            2'b00:   next_pc_s = pc_plus4_s;
            2'b01:   next_pc_s = pc_branch_s;
            2'b10:   next_pc_s = jalr_target(alu_result);
            2'b11:   next_pc_s = pc_plus4_s;
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // FSM next state plus the one-cycle strobes that update the datapath.
    always_comb begin
        state_next_s = state_r;
        pc_load_s    = 1'b0;
        capture_s    = 1'b0;
        fault_set_s  = 1'b0;
        case (state_r)
            S_REQ: begin
                // Responses are ignored here; only the request handshake matters.
                if (imem_req_ready) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = S_EXEC;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    if (is_misaligned(next_pc_s)) begin
                        // pc keeps the address of the faulting instruction.
                        fault_set_s  = 1'b1;
                        state_next_s = S_FAULT;
                    end else begin
                        pc_load_s    = 1'b1;
                        state_next_s = S_REQ;
                    end
                end else begin
                    state_next_s = S_EXEC;
                end
            end
            S_FAULT: begin
                state_next_s = S_FAULT;
            end
            default: begin
                state_next_s = S_FAULT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_REQ;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC register; only a clean retire moves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (pc_load_s) begin
            pc_r <= next_pc_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Instruction register: loaded on response, flushed to NOP on retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= NOP_INSTR;
        end else if (capture_s) begin
            instr_r <= imem_resp_data;
        end else if (pc_load_s) begin
            instr_r <= NOP_INSTR;
        end else begin
            instr_r <= instr_r;
        end
    end

    // Instruction-valid flag, set with the capture and dropped on leaving S_EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid_r <= 1'b0;
        end else if (capture_s) begin
            instr_valid_r <= 1'b1;
        end else if (pc_load_s || fault_set_s) begin
            instr_valid_r <= 1'b0;
        end else begin
            instr_valid_r <= instr_valid_r;
        end
    end

    // Sticky misaligned-target fault, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (fault_set_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    // The request strobe is decoded from state so it is high straight out of reset.
    assign imem_req_valid = (state_r == S_REQ);
    assign imem_addr      = pc_r;
    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_s;
    // Masking keeps a stale word in the register from leaking after a fault.
    assign instr          = instr_valid_r ? instr_r : NOP_INSTR;
    assign instr_valid    = instr_valid_r;
    assign fetch_fault    = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit: reset, handshake latency, back-pressure,
// sequential/branch/jalr PC updates, wrap-around, misaligned fault and
// reset during an outstanding request.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        retire;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    int total;
    int bad;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .retire          (retire),
        .pc_src          (pc_src),
        .imm_ext         (imm_ext),
        .alu_result      (alu_result),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request accepted immediately, response in the following cycle; ends in S_EXEC.
    task automatic fetch(input logic [31:0] word);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = word;
        step();
        imem_resp_valid = 1'b0;
    endtask

    // One retire cycle with the given next-PC controls.
    task automatic do_retire(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        retire     = 1'b1;
        pc_src     = src;
        imm_ext    = imm;
        alu_result = alu;
        step();
        retire     = 1'b0;
        pc_src     = 2'b00;
        imm_ext    = 32'h0000_0000;
        alu_result = 32'h0000_0000;
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0000_0000;
        retire          = 1'b0;
        pc_src          = 2'b00;
        imm_ext         = 32'h0000_0000;
        alu_result      = 32'h0000_0000;
        step();
        step();

        // Reset values.
        check("rst_pc",        pc,                   32'h0000_0000);
        check("rst_instr",     instr,                NOP);
        check("rst_valid",     {31'd0, instr_valid}, 32'd0);
        check("rst_fault",     {31'd0, fetch_fault}, 32'd0);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        rst = 1'b0;
        step();
        check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("post_rst_addr",      imem_addr,            32'h0000_0000);

        // First fetch: accept, response one cycle later, valid two cycles after accept.
        imem_req_ready = 1'b1;
        step();
        check("wait_req_low",   {31'd0, imem_req_valid}, 32'd0);
        check("wait_not_valid", {31'd0, instr_valid},    32'd0);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        step();
        imem_resp_valid = 1'b0;
        check("f1_valid",  {31'd0, instr_valid}, 32'd1);
        check("f1_instr",  instr,                32'h0050_0093);
        check("f1_pcp4",   pc_plus4,             32'h0000_0004);
        // Without retire the instruction stays put.
        step();
        check("f1_hold_instr", instr, 32'h0050_0093);
        do_retire(2'b00, 32'h0000_0000, 32'h0000_0000);
        check("r1_addr",  imem_addr,            32'h0000_0004);
        check("r1_req",   {31'd0, imem_req_valid}, 32'd1);
        check("r1_instr", instr,                NOP);

        // Back-pressure: ready low for 5 cycles, a stray response must be ignored.
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0BAD;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("bp_addr",      imem_addr,            32'h0000_0004);
            check("bp_not_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_req_low",   {31'd0, imem_req_valid}, 32'd0);
            check("rd_not_valid", {31'd0, instr_valid},    32'd0);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0033;
        step();
        imem_resp_valid = 1'b0;
        check("rd_valid", {31'd0, instr_valid}, 32'd1);
        check("rd_instr", instr,                32'h0000_0033);
        check("rd_pc",    pc,                   32'h0000_0004);
        do_retire(2'b00, 32'h0000_0000, 32'h0000_0000);
        check("to8_addr", imem_addr, 32'h0000_0008);

        // Sequential at pc=8 then backward branch from pc=12.
        fetch(32'h0000_0063);
        do_retire(2'b00, 32'h0000_0000, 32'h0000_0000);
        check("seq_addr", imem_addr, 32'h0000_000C);
        fetch(32'hFE00_0CE3);
        do_retire(2'b01, 32'hFFFF_FFF8, 32'h0000_0000);
        check("br_addr", imem_addr, 32'h0000_0004);

        // Move to pc=16 then jalr with odd target.
        fetch(32'h0000_0063);
        do_retire(2'b01, 32'h0000_000C, 32'h0000_0000);
        check("to16_addr", imem_addr, 32'h0000_0010);
        fetch(32'h0000_00E7);
        check("jalr_pcp4", pc_plus4, 32'h0000_0014);
        do_retire(2'b10, 32'h0000_0000, 32'h0000_0101);
        check("jalr_addr", imem_addr, 32'h0000_0100);

        // Wrap-around through the reserved encoding: 0xFFFF_FFFC -> 0.
        fetch(32'h0000_0063);
        do_retire(2'b01, 32'hFFFF_FEFC, 32'h0000_0000);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        check("top_pcp4", pc_plus4, 32'h0000_0000);
        do_retire(2'b11, 32'h0000_0040, 32'h0000_0080);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        fetch(32'h0000_0063);
        do_retire(2'b01, 32'h0000_0004, 32'h0000_0000);
        check("to4_addr", imem_addr, 32'h0000_0004);

        // Misaligned branch target from pc=4.
        fetch(32'h0000_0363);
        do_retire(2'b01, 32'h0000_0006, 32'h0000_0000);
        check("flt_fault", {31'd0, fetch_fault},    32'd1);
        check("flt_pc",    pc,                      32'h0000_0004);
        check("flt_valid", {31'd0, instr_valid},    32'd0);
        check("flt_instr", instr,                   NOP);
        imem_req_ready = 1'b1;
        retire         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flt_req_low", {31'd0, imem_req_valid}, 32'd0);
            check("flt_sticky",  {31'd0, fetch_fault},    32'd1);
            check("flt_pc_hold", pc,                      32'h0000_0004);
        end
        imem_req_ready = 1'b0;
        retire         = 1'b0;

        // Reset clears the fault.
        rst = 1'b1;
        #1;
        check("clr_fault", {31'd0, fetch_fault}, 32'd0);
        check("clr_pc",    pc,                   32'h0000_0000);
        step();
        rst = 1'b0;

        // Reach pc=4, get a request outstanding, then reset in S_WAIT.
        fetch(32'h0000_0013);
        do_retire(2'b00, 32'h0000_0000, 32'h0000_0000);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("w_pc",  pc,                      32'h0000_0004);
        check("w_req", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("wrst_pc",  pc,                      32'h0000_0000);
        check("wrst_req", {31'd0, imem_req_valid}, 32'd1);
        step();
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        check("stale_valid", {31'd0, instr_valid},    32'd0);
        check("stale_instr", instr,                   NOP);
        check("stale_req",   {31'd0, imem_req_valid}, 32'd1);
        check("stale_addr",  imem_addr,               32'h0000_0000);
        fetch(32'h0010_0093);
        check("new_valid", {31'd0, instr_valid}, 32'd1);
        check("new_instr", instr,                32'h0010_0093);
        check("new_pc",    pc,                   32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
